// File: rtl/keypad_pkg.sv
// Shared state encoding, key codes and helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_INC  = 4'b1111;
    localparam logic [3:0] KEY_DEC  = 4'b1101;
    localparam logic [3:0] ROW_INIT = 4'b1110;

    // Index of the lowest-numbered low bit (active-low vectors); 0 if none is low.
    function automatic logic [1:0] low_index(input logic [3:0] bits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!bits[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad columns; resets to all ones (no key).
module keypad_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] col_s
);

    logic [3:0] meta_reg;
    logic [3:0] sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= 4'hF;
            sync_reg <= 4'hF;
        end else begin
            meta_reg <= col;
            sync_reg <= meta_reg;
        end
    end

    assign col_s = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, press/release debounce, stable key code with held level.
// Define KEYPAD_REPEAT_EN to add hold-to-repeat gaps on pre while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 16,
    parameter int DEBOUNCE_CYC  = 1000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] value,
    output logic       pre
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYC);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CYC < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD <= 4) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0]        col_s;
    state_t            state_reg;
    logic [SLOT_W-1:0] slot_reg;
    logic [DEB_W-1:0]  deb_reg;
    logic [DEB_W-1:0]  deb_next;
    logic [3:0]        row_reg;
    logic [3:0]        row_next;
    logic [3:0]        value_reg;
    logic              pre_reg;
    logic [1:0]        cand_reg;
    logic              any_low;
    logic              cand_only;
    logic              cand_high;

`ifdef KEYPAD_REPEAT_EN
    localparam int GAP_CYC  = 4;
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [HOLD_W-1:0] GAP_LAST    = HOLD_W'(GAP_CYC - 1);

    logic [HOLD_W-1:0] hold_reg;
    logic              rep_reg;
`endif

    keypad_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .col   (col),
        .col_s (col_s)
    );

    assign deb_next  = deb_reg + DEB_W'(1);
    assign row_next  = {row_reg[2:0], row_reg[3]};
    assign any_low   = (col_s != 4'hF);
    assign cand_only = (col_s == ~(4'b0001 << cand_reg));
    // Only the debounced column decides release, so a second key held alongside is ignored.
    assign cand_high = col_s[cand_reg];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SCAN;
            slot_reg  <= '0;
            deb_reg   <= '0;
            row_reg   <= ROW_INIT;
            value_reg <= 4'h0;
            pre_reg   <= 1'b0;
            cand_reg  <= 2'd0;
`ifdef KEYPAD_REPEAT_EN
            hold_reg  <= '0;
            rep_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                SCAN: begin
                    if (slot_reg == SLOT_LAST) begin
                        slot_reg <= '0;
                        if (any_low) begin
                            cand_reg  <= low_index(col_s);
                            deb_reg   <= '0;
                            state_reg <= DEBOUNCE;
                        end else begin
                            row_reg <= row_next;
                        end
                    end else begin
                        slot_reg <= slot_reg + SLOT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!cand_only) begin
                        deb_reg   <= '0;
                        slot_reg  <= '0;
                        state_reg <= SCAN;
                    end else if (deb_next == DEB_LAST) begin
                        deb_reg   <= '0;
                        value_reg <= {low_index(row_reg), cand_reg};
                        pre_reg   <= 1'b1;
                        state_reg <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        hold_reg  <= '0;
                        rep_reg   <= 1'b0;
`endif
                    end else begin
                        deb_reg <= deb_next;
                    end
                end
                PRESSED: begin
                    if (cand_high) begin
                        deb_reg   <= '0;
                        state_reg <= RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        hold_reg  <= '0;
                    end else if (!pre_reg) begin
                        // Inside a repeat gap: pre comes back after GAP_CYC low cycles.
                        if (hold_reg == GAP_LAST) begin
                            pre_reg <= 1'b1;
                        end
                        hold_reg <= hold_reg + HOLD_W'(1);
                    end else if (hold_reg == (rep_reg ? PERIOD_LAST : DELAY_LAST)) begin
                        pre_reg  <= 1'b0;
                        hold_reg <= '0;
                        rep_reg  <= 1'b1;
                    end else begin
                        hold_reg <= hold_reg + HOLD_W'(1);
`endif
                    end
                end
                RELEASE: begin
                    if (!cand_high) begin
                        // Key still held: a repeat gap cut short by the bounce is closed here.
                        deb_reg   <= '0;
                        pre_reg   <= 1'b1;
                        state_reg <= PRESSED;
                    end else if (deb_next == DEB_LAST) begin
                        deb_reg   <= '0;
                        pre_reg   <= 1'b0;
                        row_reg   <= row_next;
                        slot_reg  <= '0;
                        state_reg <= SCAN;
                    end else begin
                        deb_reg <= deb_next;
                    end
                end
                default: begin
                    state_reg <= SCAN;
                end
            endcase
        end
    end

    assign row   = row_reg;
    assign value = value_reg;
    assign pre   = pre_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: switch-matrix model driven by directed presses; pre edges checked by a scoreboard.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV      = 4;
    localparam int DEBOUNCE_CYC  = 8;
    localparam int REPEAT_DELAY  = 40;
    localparam int REPEAT_PERIOD = 20;

    typedef struct {
        bit         rise;
        logic [3:0] code;
        int         t_min;
        int         t_max;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] value;
    logic       pre;
    logic [3:0] keys [4];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    exp_t       exp_q [$];
    exp_t       mon_e;
    logic       pre_prev = 1'b0;
    logic [3:0] held_code = 4'h0;
    logic [3:0] row_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_CYC  (DEBOUNCE_CYC),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .col   (col),
        .row   (row),
        .value (value),
        .pre   (pre)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Closed switch connects its column to its row; columns are pulled up otherwise.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[r][c]) col[c] = 1'b0;
            end
        end
    end

    // Monitor: every pre edge pops one expectation.
    always @(negedge clk) begin
        if (pre !== pre_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_edge: pre=%b at cycle %0d, required no edge", pre, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] cycle %0d pre %s value %b (window %0d..%0d)", cyc, pre ? "rise" : "fall", value, mon_e.t_min, mon_e.t_max);
                tests++;
                if (pre !== mon_e.rise) begin
                    fails++;
                    $display("FAIL edge_kind: pre=%b, required %b", pre, mon_e.rise);
                end
                tests++;
                if (cyc < mon_e.t_min || cyc > mon_e.t_max) begin
                    fails++;
                    $display("FAIL edge_time: cycle %0d, required %0d..%0d", cyc, mon_e.t_min, mon_e.t_max);
                end
                if (mon_e.rise) begin
                    tests++;
                    if (value !== mon_e.code) begin
                        fails++;
                        $display("FAIL rise_value: value=%b, required %b", value, mon_e.code);
                    end
                end
            end
            held_code = value;
        end else if (pre === 1'b1) begin
            tests++;
            if (value !== held_code) begin
                fails++;
                $display("FAIL value_stable: value=%b while pre high, required %b", value, held_code);
            end
        end
        pre_prev = pre;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check4(input string name, input logic [3:0] actual, input logic [3:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, actual, required);
        end
    endtask

    task automatic expect_edge(input bit rise, input logic [3:0] code, input int t_min, input int t_max);
        exp_t e;
        e.rise  = rise;
        e.code  = code;
        e.t_min = t_min;
        e.t_max = t_max;
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] code_of(input int r, input int c);
        return 4'((r << 2) | c);
    endfunction

    // Wait until row r has just become the driven row.
    task automatic wait_row(input int r);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << r);
        n = 0;
        while (row === want && n < 40) begin @(negedge clk); n++; end
        while (row !== want && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (row !== want) begin
            fails++;
            $display("FAIL row_wait: row=%b, required %b within 40 cycles", row, want);
        end
    endtask

    task automatic wait_pre(input logic level, input int limit);
        int n;
        n = 0;
        while (pre !== level && n < limit) begin @(negedge clk); n++; end
        tests++;
        if (pre !== level) begin
            fails++;
            $display("FAIL pre_wait: pre=%b after %0d cycles, required %b", pre, limit, level);
        end
    endtask

    task automatic press(input int r, input int c);
        wait_row(r);
        keys[r][c] = 1'b1;
        expect_edge(1'b1, code_of(r, c), cyc + 10, cyc + 14);
    endtask

    task automatic release_key(input int r, input int c);
        keys[r][c] = 1'b0;
        expect_edge(1'b0, 4'h0, cyc + 10, cyc + 10);
    endtask

    initial begin
        int t;
        for (int r = 0; r < 4; r++) keys[r] = 4'h0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;

        // Idle scan after reset
        check4("reset_value", value, 4'h0);
        check4("reset_pre", {3'b000, pre}, 4'h0);
        for (int k = 0; k < 16; k++) begin
            check4("idle_row", row, row_seq[(k / 4) % 4]);
            step(1);
        end

        // Clean press and release of the increment key
        press(3, 3);
        wait_pre(1'b1, 30);
        check4("inc_code", value, KEY_INC);
        step(6);
        release_key(3, 3);
        wait_pre(1'b0, 20);

        // Bouncing press on row 0 / col 1
        wait_row(0);
        keys[0][1] = 1'b1;
        step(3);
        keys[0][1] = 1'b0;
        step(2);
        keys[0][1] = 1'b1;
        expect_edge(1'b1, 4'b0001, cyc + 8, cyc + 16);
        wait_pre(1'b1, 30);
        step(4);
        release_key(0, 1);
        wait_pre(1'b0, 20);

        // Second key while held, first released: second becomes a new press
        press(3, 1);
        wait_pre(1'b1, 30);
        check4("dec_code", value, KEY_DEC);
        step(3);
        keys[3][2] = 1'b1;
        step(5);
        release_key(3, 1);
        expect_edge(1'b1, 4'b1110, cyc + 10, cyc + 50);
        wait_pre(1'b0, 20);
        wait_pre(1'b1, 50);
        step(4);
        release_key(3, 2);
        wait_pre(1'b0, 20);

        // Reset while a key is held
        press(3, 3);
        wait_pre(1'b1, 30);
        step(5);
        t = cyc;
        expect_edge(1'b0, 4'h0, t + 1, t + 1);
        expect_edge(1'b1, KEY_INC, t + 10, t + 40);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check4("midpress_reset_row", row, ROW_INIT);
        check4("midpress_reset_pre", {3'b000, pre}, 4'h0);
        wait_pre(1'b1, 40);
        step(4);
        release_key(3, 3);
        wait_pre(1'b0, 20);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat gaps while held
        press(3, 3);
        wait_pre(1'b1, 30);
        t = cyc;
        expect_edge(1'b0, 4'h0, t + 40, t + 40);
        expect_edge(1'b1, KEY_INC, t + 44, t + 44);
        expect_edge(1'b0, 4'h0, t + 60, t + 60);
        expect_edge(1'b1, KEY_INC, t + 64, t + 64);
        expect_edge(1'b0, 4'h0, t + 80, t + 80);
        expect_edge(1'b1, KEY_INC, t + 84, t + 84);
        step(90);
        release_key(3, 3);
        wait_pre(1'b0, 20);
`endif

        step(5);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_edges: %0d expected edges not seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
